io_uart: RTL and testbench

- Byte-wide serial peripheral on the CPU core's IO port, directly downstream of the core.
- The core's `ioout`/`iowrite` strobe feeds a TX FIFO, which the block serializes onto `txd` as 8N1 frames.
- Frames received on `rxd` are deserialized into an RX FIFO. The FIFO head drives the core's `ioin`, and `ioread` pops it.
- `int` requests service whenever received data is waiting.

---
 rtl/io_uart.sv | 252 +++++++++++++++++++++++++
 tb/tb_io_uart.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart.sv
// Byte-wide UART on the core IO port: TX FIFO + 8N1 serializer, 2-flop RX
// synchronizer + deserializer + RX FIFO whose head drives the read port.
module io_uart #(
  parameter int unsigned CLKDIV = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_ioout,
  input  logic       i_iowrite,
  input  logic       i_ioread,
  input  logic       i_rxd,
  output logic [7:0] o_ioin,
  output logic       o_int,
  output logic       o_txd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(CLKDIV);
  localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [CW-1:0] DivLast  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKDIV / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]  r_tx_mem [DEPTH];
  logic [AW:0] r_tx_wp, r_tx_rp;
  logic        w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [7:0]  w_tx_head;

  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
  // A full FIFO still accepts a byte when the serializer pops in the same cycle.
  assign w_tx_push  = i_iowrite && (!w_tx_full || w_tx_pop);
  assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];

  // TX storage write
  always_ff @(posedge i_clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= i_ioout;
  end

  // TX pointer update
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_wp <= '0;
      r_tx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PtrOne;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PtrOne;
    end
  end

  // ---------------- TX serializer ----------------
  state_e        r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_txd, w_txd_nxt;

  // TX state register; txd is registered so it changes only on edges
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_state <= StIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // TX next-state: w_txd_nxt is the line level for the bit period being entered
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_txd_nxt      = r_txd;
    w_tx_pop       = 1'b0;
    unique case (r_tx_state)
      StIdle: begin
        w_txd_nxt = 1'b1;
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_tx_head;
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = StStart;
          w_txd_nxt      = 1'b0;
        end
      end
      StStart: begin
        if (r_tx_cnt == DivLast) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = StData;
          w_txd_nxt      = r_tx_shift[0];
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CntOne;
        end
      end
      StData: begin
        if (r_tx_cnt == DivLast) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = StStop;
            w_txd_nxt      = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_txd_nxt      = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CntOne;
        end
      end
      StStop: begin
        if (r_tx_cnt == DivLast) begin
          w_tx_cnt_nxt = '0;
          if (!w_tx_empty) begin
            // Chain straight into the next frame with no idle gap.
            w_tx_pop       = 1'b1;
            w_tx_shift_nxt = w_tx_head;
            w_tx_state_nxt = StStart;
            w_txd_nxt      = 1'b0;
          end else begin
            w_tx_state_nxt = StIdle;
            w_txd_nxt      = 1'b1;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CntOne;
        end
      end
      default: w_tx_state_nxt = StIdle;
    endcase
  end

  assign o_txd = r_txd;

  // ---------------- RX deserializer ----------------
  logic          r_rx_meta, r_rx_sync;
  state_e        r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          w_rx_push;

  // RX synchronizer and state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= StIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= i_rxd;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // RX next-state: half-bit wait in START puts later samples near bit centres
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    unique case (r_rx_state)
      StIdle: begin
        if (!r_rx_sync) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = StStart;
        end
      end
      StStart: begin
        if (r_rx_cnt == HalfLast) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_sync ? StIdle : StData;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CntOne;
        end
      end
      StData: begin
        if (r_rx_cnt == DivLast) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_nxt = StStop;
          else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CntOne;
        end
      end
      StStop: begin
        if (r_rx_cnt == DivLast) begin
          w_rx_cnt_nxt   = '0;
          w_rx_push      = r_rx_sync;
          w_rx_state_nxt = StIdle;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CntOne;
        end
      end
      default: w_rx_state_nxt = StIdle;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]  r_rx_mem [DEPTH];
  logic [AW:0] r_rx_wp, r_rx_rp;
  logic        w_rx_empty, w_rx_full, w_rx_wr, w_rx_pop;

  assign w_rx_empty = (r_rx_wp == r_rx_rp);
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_rx_pop   = i_ioread && !w_rx_empty;
  assign w_rx_wr    = w_rx_push && (!w_rx_full || w_rx_pop);

  // RX storage write
  always_ff @(posedge i_clock) begin
    if (w_rx_wr) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_shift_nxt_byte();
  end

  function automatic logic [7:0] r_rx_shift_nxt_byte();
    return w_rx_shift_nxt;
  endfunction

  // RX pointer update
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_wp <= '0;
      r_rx_rp <= '0;
    end else begin
      if (w_rx_wr)  r_rx_wp <= r_rx_wp + PtrOne;
      if (w_rx_pop) r_rx_rp <= r_rx_rp + PtrOne;
    end
  end

  assign o_ioin = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[AW-1:0]];
  assign o_int  = !w_rx_empty;

endmodule

// File: tb/tb_io_uart.sv
// Scoreboard bench for io_uart: stimulus queues expected TX frames and RX reads,
// independent monitors decode txd and compare reads as they happen.
module tb_io_uart;
  localparam int unsigned CLKDIV = 4;
  localparam int unsigned DEPTH  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ioout = 8'h00;
  logic       iowrite = 1'b0;
  logic       ioread = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       rxd;
  logic [7:0] ioin;
  logic       irq;
  logic       txd;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  bit tx_busy = 1'b0;

  assign rxd = loopback ? txd : rxd_drv;

  io_uart #(.CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_ioout  (ioout),
    .i_iowrite(iowrite),
    .i_ioread (ioread),
    .i_rxd    (rxd),
    .o_ioin   (ioin),
    .o_int    (irq),
    .o_txd    (txd)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    ioout = b;
    iowrite = 1'b1;
    hold(1);
    iowrite = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd_drv = 1'b0;
    hold(CLKDIV);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      hold(CLKDIV);
    end
    rxd_drv = stop_bit;
    hold(CLKDIV);
    rxd_drv = 1'b1;
    hold(3 * CLKDIV);
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while ((tx_exp.size() != 0 || tx_busy) && n < 1000) begin
      @(posedge clock);
      n++;
    end
    #1;
    checks++;
    if (n >= 1000) begin
      failures++;
      $display("FAIL tx_drain: %0d frames still outstanding after %0d cycles", tx_exp.size(), n);
    end
  endtask

  // TX monitor: decodes each frame with per-bit timing checks, compares to queue
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && txd == 1'b0) begin
        logic [7:0] b;
        logic [7:0] e;
        logic v;
        bit ok;
        bit abort;
        tx_busy = 1'b1;
        ok = 1'b1;
        abort = 1'b0;
        b = 8'h00;
        for (int s = 1; s < CLKDIV; s++) begin
          @(negedge clock);
          if (reset) abort = 1'b1;
          if (txd !== 1'b0) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          v = 1'b0;
          for (int s = 0; s < CLKDIV; s++) begin
            @(negedge clock);
            if (reset) abort = 1'b1;
            if (s == 0) v = txd;
            else if (txd !== v) ok = 1'b0;
          end
          b[i] = v;
        end
        for (int s = 0; s < CLKDIV; s++) begin
          @(negedge clock);
          if (reset) abort = 1'b1;
          if (txd !== 1'b1) ok = 1'b0;
        end
        if (!abort) begin
          chk("tx_frame_timing", {31'd0, ok}, 32'd1);
          if (tx_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected_frame: got %0h expected no frame", b);
          end else begin
            e = tx_exp.pop_front();
            chk("tx_byte", {24'd0, b}, {24'd0, e});
          end
        end
        tx_busy = 1'b0;
      end
    end
  end

  // Read monitor: each cycle with ioread high, ioin must equal the next expected byte
  initial begin
    forever begin
      @(negedge clock);
      if (ioread && !reset) begin
        logic [7:0] e;
        if (rx_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected_read: got %0h expected no read", ioin);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_read", {24'd0, ioin}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    int n;
    hold(3);
    reset = 1'b0;
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_int", {31'd0, irq}, 32'd0);
    chk("reset_ioin", {24'd0, ioin}, 32'h00);

    // Single frame A5: first fall one edge after the write edge.
    tx_exp.push_back(8'hA5);
    ioout = 8'hA5;
    iowrite = 1'b1;
    hold(1);
    iowrite = 1'b0;
    chk("tx_still_idle_at_write_edge", {31'd0, txd}, 32'd1);
    hold(1);
    chk("tx_start_after_one_edge", {31'd0, txd}, 32'd0);
    wait_tx_drain();
    hold(4);

    // Burst of six writes into a depth-4 FIFO: 01..05 sent back-to-back, 06 dropped.
    for (int i = 1; i <= 5; i++) tx_exp.push_back(8'(i));
    for (int i = 1; i <= 6; i++) begin
      ioout = 8'(i);
      iowrite = 1'b1;
      hold(1);
    end
    iowrite = 1'b0;
    hold(200 - 6);
    chk("tx_high_at_200", {31'd0, txd}, 32'd1);
    wait_tx_drain();
    hold(4);

    // Loopback 3C: int after about one frame plus synchronizer latency.
    loopback = 1'b1;
    tx_exp.push_back(8'h3C);
    write_byte(8'h3C);
    n = 0;
    while (!irq && n < 100) begin
      hold(1);
      n++;
    end
    checks++;
    if (n < 10 * CLKDIV - 4 || n > 10 * CLKDIV + 6) begin
      failures++;
      $display("FAIL loop_int_latency: got %0d cycles expected about %0d", n, 10 * CLKDIV + 3);
    end
    chk("loop_ioin", {24'd0, ioin}, 32'h3C);
    rx_exp.push_back(8'h3C);
    ioread = 1'b1;
    hold(1);
    ioread = 1'b0;
    chk("loop_int_after_pop", {31'd0, irq}, 32'd0);
    chk("loop_ioin_after_pop", {24'd0, ioin}, 32'h00);
    wait_tx_drain();
    loopback = 1'b0;
    hold(4 * CLKDIV);

    // One-cycle glitch and a framing error must both push nothing.
    rxd_drv = 1'b0;
    hold(1);
    rxd_drv = 1'b1;
    hold(20);
    chk("glitch_no_push", {31'd0, irq}, 32'd0);
    send_frame(8'h5A, 1'b0);
    hold(10);
    chk("framing_no_push", {31'd0, irq}, 32'd0);
    chk("framing_ioin", {24'd0, ioin}, 32'h00);

    // Five frames, no reads: fifth dropped, first four read back in order.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    chk("rx_full_int", {31'd0, irq}, 32'd1);
    chk("rx_full_head", {24'd0, ioin}, 32'h11);
    rx_exp.push_back(8'h11);
    rx_exp.push_back(8'h22);
    rx_exp.push_back(8'h33);
    rx_exp.push_back(8'h44);
    ioread = 1'b1;
    hold(4);
    ioread = 1'b0;
    chk("rx_drained_int", {31'd0, irq}, 32'd0);
    chk("rx_drained_ioin", {24'd0, ioin}, 32'h00);
    // Read on an empty FIFO is harmless.
    rx_exp.push_back(8'h00);
    ioread = 1'b1;
    hold(1);
    ioread = 1'b0;
    chk("rx_empty_read_int", {31'd0, irq}, 32'd0);

    // Reset mid-frame: line returns high next edge, queued bytes are discarded.
    tx_exp.push_back(8'h00);
    write_byte(8'h00);
    write_byte(8'h77);
    write_byte(8'h88);
    hold(15);
    chk("pre_reset_txd_low", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    hold(1);
    chk("reset_mid_frame_txd", {31'd0, txd}, 32'd1);
    hold(2);
    reset = 1'b0;
    tx_exp.delete();
    hold(60);
    chk("post_reset_idle_txd", {31'd0, txd}, 32'd1);
    tx_exp.push_back(8'h5A);
    write_byte(8'h5A);
    wait_tx_drain();
    hold(60);

    chk("tx_queue_empty", tx_exp.size(), 32'd0);
    chk("rx_queue_empty", rx_exp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
